// File: rtl/video_pkg.sv
// Shared video-pipeline definitions: default pixel width, 3x3 window tap layout
// and a helper that sizes raster counters.
package video_pkg;

    localparam int DW       = 8;
    localparam int WIN_TAPS = 9;

    // Tap index: row 1 = oldest line, column 1 = oldest pixel; P11 sits at the MSBs.
    localparam int P11 = 0;
    localparam int P12 = 1;
    localparam int P13 = 2;
    localparam int P21 = 3;
    localparam int P22 = 4;
    localparam int P23 = 5;
    localparam int P31 = 6;
    localparam int P32 = 7;
    localparam int P33 = 8;

    function automatic int win_lsb(input int idx, input int dw);
        return (WIN_TAPS - 1 - idx) * dw;
    endfunction

    localparam int P11_LSB = (WIN_TAPS - 1 - P11) * DW;
    localparam int P12_LSB = (WIN_TAPS - 1 - P12) * DW;
    localparam int P13_LSB = (WIN_TAPS - 1 - P13) * DW;
    localparam int P21_LSB = (WIN_TAPS - 1 - P21) * DW;
    localparam int P22_LSB = (WIN_TAPS - 1 - P22) * DW;
    localparam int P23_LSB = (WIN_TAPS - 1 - P23) * DW;
    localparam int P31_LSB = (WIN_TAPS - 1 - P31) * DW;
    localparam int P32_LSB = (WIN_TAPS - 1 - P32) * DW;
    localparam int P33_LSB = (WIN_TAPS - 1 - P33) * DW;

    // Bits needed to hold the values 0..n-1 (at least one bit).
    function automatic int cnt_bits(input int n);
        int b;
        b = 1;
        while ((1 << b) < n) begin
            b = b + 1;
        end
        return b;
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// One video line of pixels: simple dual-port RAM, synchronous read-first port,
// no reset so it maps onto block RAM.
module line_buffer_ram #(
    parameter int DEPTH = 640,
    parameter int DW    = 8,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/y_window_3x3.sv
// 3x3 luma neighbourhood builder: two line buffers plus three shift rows, with
// x/y raster tracking so only windows fully inside the frame are flagged valid.
module y_window_3x3 import video_pkg::*; #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DW         = video_pkg::DW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   i_y_8b,
    input  logic            i_h_sync,
    input  logic            i_v_sync,
    input  logic            i_data_en,
    output logic [9*DW-1:0] o_win,
    output logic            o_win_valid,
    output logic            o_h_sync,
    output logic            o_v_sync,
    output logic            o_data_en
);

    localparam int XW = cnt_bits(IMG_WIDTH);
    localparam int YW = cnt_bits(IMG_HEIGHT);

    logic          vs_prev_q;
    logic          vs_rise;
    logic [XW-1:0] x_q, x_d, x_cur;
    logic [YW-1:0] y_q, y_d, y_cur;
    logic          valid_d;
    logic [XW-1:0] x_p1_q;
    logic [DW-1:0] pix_p1_q;
    logic          valid_p1_q, valid_p2_q;
    logic [1:0]    hs_q, vs_q, de_q;
    logic [DW-1:0] rd1, rd2;
    logic [DW-1:0] row_in [3];
    logic [DW-1:0] win_q [3][3];

    // A frame-start edge overrides the counters in the same cycle it is seen.
    always_comb begin
        vs_rise = i_v_sync & ~vs_prev_q;
        x_cur   = vs_rise ? '0 : x_q;
        y_cur   = vs_rise ? '0 : y_q;
        x_d     = x_cur;
        y_d     = y_cur;
        if (i_data_en) begin
            if (x_cur == XW'(IMG_WIDTH - 1)) begin
                x_d = '0;
                if (y_cur != YW'(IMG_HEIGHT - 1)) begin
                    y_d = y_cur + YW'(1);
                end
            end else begin
                x_d = x_cur + XW'(1);
            end
        end
        valid_d = i_data_en && (x_cur >= XW'(2)) && (y_cur >= YW'(2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q  <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            x_p1_q     <= '0;
            pix_p1_q   <= '0;
            valid_p1_q <= 1'b0;
            valid_p2_q <= 1'b0;
            hs_q       <= '0;
            vs_q       <= '0;
            de_q       <= '0;
        end else begin
            vs_prev_q  <= i_v_sync;
            x_q        <= x_d;
            y_q        <= y_d;
            x_p1_q     <= x_cur;
            pix_p1_q   <= i_y_8b;
            valid_p1_q <= valid_d;
            valid_p2_q <= valid_p1_q;
            hs_q       <= {hs_q[0], i_h_sync};
            vs_q       <= {vs_q[0], i_v_sync};
            de_q       <= {de_q[0], i_data_en};
        end
    end

    line_buffer_ram #(.DEPTH(IMG_WIDTH), .DW(DW), .AW(XW)) u_lb1 (
        .clk     (clk),
        .we_i    (i_data_en),
        .waddr_i (x_cur),
        .wdata_i (i_y_8b),
        .raddr_i (x_cur),
        .rdata_o (rd1)
    );

    // LB2 receives LB1's old value one cycle later, once the synchronous read returns.
    line_buffer_ram #(.DEPTH(IMG_WIDTH), .DW(DW), .AW(XW)) u_lb2 (
        .clk     (clk),
        .we_i    (de_q[0]),
        .waddr_i (x_p1_q),
        .wdata_i (rd1),
        .raddr_i (x_cur),
        .rdata_o (rd2)
    );

    assign row_in[0] = rd2;
    assign row_in[1] = rd1;
    assign row_in[2] = pix_p1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (de_q[0]) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
                win_q[r][2] <= row_in[r];
            end
        end
    end

    for (genvar gi = 0; gi < 9; gi++) begin : g_pack
        assign o_win[win_lsb(gi, DW) +: DW] = win_q[gi / 3][gi % 3];
    end

    assign o_win_valid = valid_p2_q;
    assign o_h_sync    = hs_q[1];
    assign o_v_sync    = vs_q[1];
    assign o_data_en   = de_q[1];

endmodule

// File: tb/tb_y_window_3x3.sv
// Scoreboard bench for y_window_3x3 on an 8x4 image: a pixel-sequence model
// predicts each window, a negedge monitor pops and compares.
module tb_y_window_3x3;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam logic [71:0] REF_X3Y2 =
        {8'd1, 8'd2, 8'd3, 8'd17, 8'd18, 8'd19, 8'd33, 8'd34, 8'd35};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  i_y_8b = '0;
    logic        i_h_sync = 1'b0;
    logic        i_v_sync = 1'b0;
    logic        i_data_en = 1'b0;
    logic [71:0] o_win;
    logic        o_win_valid, o_h_sync, o_v_sync, o_data_en;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    y_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_y_8b      (i_y_8b),
        .i_h_sync    (i_h_sync),
        .i_v_sync    (i_v_sync),
        .i_data_en   (i_data_en),
        .o_win       (o_win),
        .o_win_valid (o_win_valid),
        .o_h_sync    (o_h_sync),
        .o_v_sync    (o_v_sync),
        .o_data_en   (o_data_en)
    );

    typedef struct {
        logic [7:0]  pix;
        bit          valid;
        logic [71:0] win;
        int          x;
        int          y;
        int          frame;
    } exp_t;

    exp_t sbq[$];
    int   seq[$];
    int   mx = 0;
    int   my = 0;
    bit   m_vs_prev = 1'b0;
    int   frame_id = 0;
    int   fbase [int];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Window = last three lines of accepted pixels since frame start, indexed by sequence.
    task automatic model_step(input bit de, input bit vs, input int pix);
        exp_t e;
        int   n;
        if (vs && !m_vs_prev) begin
            mx = 0;
            my = 0;
            seq.delete();
        end
        m_vs_prev = vs;
        if (de) begin
            n = seq.size();
            seq.push_back(pix);
            e.pix   = 8'(pix);
            e.valid = (mx >= 2) && (my >= 2);
            e.win   = '0;
            e.x     = mx;
            e.y     = my;
            e.frame = frame_id;
            if (e.valid) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        e.win[(8 - (r * 3 + c)) * 8 +: 8] = 8'(seq[n - (2 - r) * W - (2 - c)]);
                    end
                end
            end
            sbq.push_back(e);
            if (mx == W - 1) begin
                mx = 0;
                if (my < H - 1) my++;
            end else begin
                mx++;
            end
        end
    endtask

    task automatic drive(input bit de, input bit hs, input bit vs, input int pix);
        @(posedge clk);
        #1;
        i_data_en = de;
        i_h_sync  = hs;
        i_v_sync  = vs;
        i_y_8b    = 8'(pix);
        if (rst_n) model_step(de, vs, pix);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1;
        check("sb_empty_before_reset", 72'(sbq.size()), 72'd0);
        rst_n = 1'b0;
        sbq.delete();
        seq.delete();
        mx = 0;
        my = 0;
        m_vs_prev = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        i_data_en = 1'b0;
        i_h_sync  = 1'b0;
        i_v_sync  = 1'b0;
    endtask

    task automatic send_frame(input int base, input int lines, input bit gaps,
                              input bit coincide, input int stop_line, input int stop_x);
        bit vs;
        frame_id++;
        fbase[frame_id] = base;
        if (!coincide) begin
            drive(1'b0, 1'b0, 1'b1, int'($urandom_range(0, 255)));
            drive(1'b0, 1'b0, 1'b1, int'($urandom_range(0, 255)));
        end
        for (int l = 0; l < lines; l++) begin
            for (int x = 0; x < W; x++) begin
                vs = coincide && (l == 0) && (x == 0);
                drive(1'b1, 1'b0, vs, base + 16 * l + x);
                if (l == stop_line && x == stop_x) return;
                if (gaps && x < W - 1 && $urandom_range(0, 1) == 1) begin
                    repeat ($urandom_range(1, 5)) drive(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 255)));
                end
            end
            drive(1'b0, 1'b1, 1'b0, int'($urandom_range(0, 255)));
            drive(1'b0, 1'b1, 1'b0, int'($urandom_range(0, 255)));
            drive(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 255)));
        end
    endtask

    // Reference 2-cycle delay of the input syncs.
    logic [2:0] sh1, sh2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh1 <= '0;
            sh2 <= '0;
        end else begin
            sh1 <= {i_h_sync, i_v_sync, i_data_en};
            sh2 <= sh1;
        end
    end

    exp_t        mon_e;
    logic [71:0] last_win = '0;
    bit          last_rst = 1'b0;
    logic [71:0] formula_win;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_win", o_win, 72'd0);
            check("reset_ctl", 72'({o_win_valid, o_h_sync, o_v_sync, o_data_en}), 72'd0);
        end else begin
            check("sync_delay", 72'({o_h_sync, o_v_sync, o_data_en}), 72'(sh2));
            if (o_data_en) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got win %h with empty scoreboard, expected none", o_win);
                end else begin
                    mon_e = sbq.pop_front();
                    $display("txn f=%0d x=%0d y=%0d valid=%0b win=%h", mon_e.frame, mon_e.x, mon_e.y,
                             o_win_valid, o_win);
                    check("valid", 72'(o_win_valid), 72'(mon_e.valid));
                    check("newest_pix", 72'(o_win[7:0]), 72'(mon_e.pix));
                    if (mon_e.valid) check("window", o_win, mon_e.win);
                    if (mon_e.frame == 1 && mon_e.x == 3 && mon_e.y == 2)
                        check("win_x3_y2", o_win, REF_X3Y2);
                    if (mon_e.valid && mon_e.x == 2 && mon_e.y == 2 && fbase.exists(mon_e.frame)) begin
                        for (int r = 0; r < 3; r++) begin
                            for (int c = 0; c < 3; c++) begin
                                formula_win[(8 - (r * 3 + c)) * 8 +: 8] = 8'(fbase[mon_e.frame] + 16 * r + c);
                            end
                        end
                        check("first_valid_win", o_win, formula_win);
                    end
                end
            end else if (last_rst) begin
                check("hold_in_gap", o_win, last_win);
            end
        end
        last_win = o_win;
        last_rst = rst_n;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(5);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 0);

        // First accepted pixel after reset lands on the newest tap exactly 2 clk later.
        drive(1'b1, 1'b0, 1'b0, 8'h5A);
        drive(1'b0, 1'b0, 1'b0, 8'h11);
        check("latency_not_early", 72'(o_win[7:0]), 72'd0);
        drive(1'b0, 1'b0, 1'b0, 8'h22);
        check("latency_2clk", 72'(o_win[7:0]), 72'h5A);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 0);

        // Continuous ramp, one line beyond the height so y saturates.
        send_frame(0, H + 1, 1'b0, 1'b0, -1, -1);
        // Gappy second frame, frame start coincides with its first pixel.
        send_frame(100, H, 1'b1, 1'b1, -1, -1);
        // Interrupted frame, reset at y=2, x=4.
        send_frame(50, H, 1'b0, 1'b0, 2, 4);
        repeat (4) drive(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 255)));
        do_reset(4);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 0);
        send_frame(200, H, 1'b0, 1'b0, -1, -1);

        repeat (5) drive(1'b0, 1'b0, 1'b0, 0);
        check("sb_drained", 72'(sbq.size()), 72'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/y_window_3x3.md
# y_window_3x3

Builds a 3×3 luma neighbourhood window from the raster Y stream produced by the RGB565→YCbCr stage and presents it, with matching sync signals, to the Sobel gradient stage. It holds the two preceding image lines in two cascaded line buffers and three shift registers. The window is qualified so that downstream only computes on windows whose nine pixels all lie inside the current frame.

## Interface
- IMG_WIDTH, 640: active pixels per line; line-buffer depth.
- IMG_HEIGHT, 480: active lines per frame; sizes the row counter.
- DW, 8: pixel width.
- clk  in  1  pixel clock, same domain as upstream.
- rst_n  in  1  reset, asynchronous, active-low.
- i_y_8b  in  DW  luma pixel.
- i_h_sync, i_v_sync, i_data_en  in  1 each  upstream syncs; i_v_sync active-high, frame start = rising edge.
- o_win  out  9*DW  window, p11 at MSBs … p33 at LSBs; row 1 = oldest line, column 1 = oldest pixel.
- o_win_valid  out  1  all nine pixels belong to the current frame.
- o_h_sync, o_v_sync, o_data_en  out  1 each  inputs delayed to match o_win.

## Operation
- A pixel is accepted when i_data_en=1. Gaps are allowed anywhere, including mid-line; window state holds during gaps.
- Column counter x counts 0..IMG_WIDTH-1 on accepted pixels and wraps to 0 after IMG_WIDTH-1.
- Row counter y increments on that wrap and saturates at IMG_HEIGHT-1.
- Both counters clear to 0 on a rising edge of i_v_sync. If a rising edge coincides with an accepted pixel, the clear wins and the pixel is treated as x=0, y=0.
- Per accepted pixel at column x:
  - rd1=LB1[x] and rd2=LB2[x] are read with read-before-write semantics.
  - LB1[x]←i_y_8b and LB2[x]←rd1 are written.
- Next cycle, each window row shifts left by one pixel: bottom row takes the delayed pixel, middle row takes rd1, top row takes rd2.
- o_win_valid = delayed(accepted AND x≥2 AND y≥2). The window centre is pixel (x-1, y-1).
  - Output row 0, output column 0, and the last row/column are never valid.
  - Downstream forces those positions to 0.
- Line buffers are not cleared at reset or frame start. Stale contents are masked by o_win_valid.

## Timing
- Latency is exactly 2 clk from an accepted input to the o_win update, for all inputs.
- o_h_sync, o_v_sync and o_data_en are 2-stage delays of the inputs and stay cycle-aligned with o_win and o_win_valid.
- o_win changes only in the cycle 2 clk after an accepted pixel and otherwise holds.
- Reset values:
  - o_win = 0.
  - o_win_valid, o_h_sync, o_v_sync, o_data_en = 0.
  - x, y, and the sync/accept delay pipes = 0.
- Reset mid-frame: all outputs are 0 on the next edge and valid stays low until two full lines have been accepted after the next frame start. Without a new frame start, counting resumes from x=0, y=0.
- Line-buffer RAM read is synchronous, 1 cycle.

## Structure
- Shared package `video_pkg`:
  - DW.
  - Window index constants P11..P33 with their bit offsets into o_win.
  - A function for the number of bits needed to count to N, used to size the x and y counters.
- Sub-module `line_buffer_ram`: simple dual-port memory, IMG_WIDTH×DW, synchronous read-first, one instance per line. It must infer block RAM.
- Counters, shift window and sync delays stay in the top level.

## Test plan
Bench runs IMG_WIDTH=8, IMG_HEIGHT=4, with pixel = 16·y + x.
- Reset: hold rst_n low with random inputs, then release → every output is 0; the first accepted pixel appears on o_win[DW-1:0] after exactly 2 clk.
- Ramp frame, continuous de → for input x=3, y=2, o_win = {1,2,3, 17,18,19, 33,34,35} and o_win_valid=1; o_win_valid is 0 for every pixel with y<2 or x<2.
- Sync alignment → o_h_sync, o_v_sync and o_data_en equal their inputs delayed by exactly 2 clk across the whole frame.
- Random de gaps of 1–5 cycles inside lines → window sequence is identical to the continuous run; o_win holds during gaps.
- Second frame with different data (pixel+100) → the first valid window contains only frame-2 values; y cleared by the i_v_sync rise.
- Reset asserted at y=2, x=4, released, then a new frame sent → outputs are 0 during reset; first valid window at y=2, x=2 contains only new-frame data.
